imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//   Shares the single combinational-read port of the instruction memory between
//   N_REQ requesters (core fetch, boot loader/debug reader, ...).
//   Valid/ready request channel and valid/ready response channel per requester.
//   One transaction in flight; the response is registered (1-cycle latency).
//   Back-to-back grants give 1 word/cycle throughput.
// PARAMETERS
//   IMEM_W  13  byte-address width of the instruction memory port
//   N_REQ   2   number of requesters (>=2); index 0 = core fetch
// PORTS
//   clk_i          in   1            clock
//   rst_i          in   1            async reset, active-high
//   req_valid_i    in   N_REQ        request valid, one bit per requester
//   req_addr_i     in   N_REQ*IMEM_W byte address per requester, packed [N_REQ-1:0][IMEM_W-1:0]
//   req_ready_o    out  N_REQ        request accepted this cycle (one-hot or zero)
//   rsp_valid_o    out  N_REQ        response valid for the owning requester (one-hot or zero)
//   rsp_data_o     out  32           response word, shared bus, meaningful only where rsp_valid_o=1
//   rsp_ready_i    in   N_REQ        requester accepts its response
//   mem_addr_o     out  IMEM_W       address to instruction memory
//   mem_rdata_i    in   32           combinational read data from instruction memory
// BEHAVIOUR
//   - Reset values: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, mem_addr_o=0,
//     state=IDLE, round-robin pointer=0, owner=0.
//   - FSM states:
//     - IDLE: no response held.
//     - RESP: response held for `owner`.
//   - can_accept = (state==IDLE) | (state==RESP & rsp_ready_i[owner]).
//   - Grant: if can_accept and |req_valid_i, the arbiter picks winner w.
//     - req_ready_o[w]=1 in that cycle; mem_addr_o=req_addr_i[w] combinationally.
//     - At the clock edge: rsp_data_q<=mem_rdata_i, owner<=w, state<=RESP.
//   - No grant:
//     - mem_addr_o = last granted address (registered). No toggling when idle.
//     - RESP with rsp_ready_i[owner]=1 -> IDLE. Otherwise state holds.
//   - Latency: a request accepted at edge N presents rsp_valid_o[w]=1 after edge N
//     and holds it, with stable data, until rsp_ready_i[w]=1.
//   - Simultaneous response retire + new grant in the same cycle is legal.
//     state stays RESP; owner/data are replaced. This is the back-to-back case.
//   - Round-robin: search starts at pointer. After a grant, pointer<=(w+1) mod N_REQ.
//     Pointer is unchanged when there is no grant.
//   - Requester protocol: addr must stay stable while valid & !ready.
//     The arbiter does not check this.
//   - Address bits [1:0] are forwarded unchanged. The memory ignores them; no alignment error.
//   - rsp_ready_i of non-owners is ignored.
//   - Reset mid-transaction: the held response is dropped; no response is ever emitted for it.
// CONFIGURATION
//   - IMEM_ARB_FIXED_PRIO_EN defined:
//     - Fixed priority; the lowest index wins (core fetch always first).
//     - Pointer logic is removed.
//   - IMEM_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// STRUCTURE
//   - Package imem_arb_pkg:
//     - typedef enum logic {IDLE, RESP} arb_state_e
//     - localparam N_REQ_DEF=2
//     - function onehot_to_idx
//   - Sub-module rr_arbiter #(N):
//     - inputs: clk_i, rst_i, req[N], advance
//     - outputs: gnt_onehot[N], gnt_idx
//     - holds the pointer internally
//     - becomes a priority encoder under IMEM_ARB_FIXED_PRIO_EN
//   - The top level holds the FSM, owner/data/address registers and the channel muxing.
// TESTING
//   1. Single request:
//      - Stimulus: req_valid_i=01, addr0=0x010; memory returns 0xDEADBEEF.
//      - Response: req_ready_o=01 same cycle; mem_addr_o=0x010; next cycle
//        rsp_valid_o=01, rsp_data_o=0xDEADBEEF.
//   2. Backpressure:
//      - Stimulus: rsp_ready_i=0 for 3 cycles.
//      - Response: rsp_valid_o and data stable for all 3 cycles; req_ready_o=00
//        throughout; retire on the 4th cycle.
//   3. Round-robin:
//      - Stimulus: both requesters valid every cycle, rsp_ready_i=11.
//      - Response: grants alternate 0,1,0,1; one response per cycle; data matches
//        each requester's address.
//      - With IMEM_ARB_FIXED_PRIO_EN: always requester 0.
//   4. Back-to-back:
//      - Stimulus: retire owner 0 and accept requester 1 in the same cycle.
//      - Response: rsp_valid_o goes 01 -> 10 with no bubble; no lost or duplicated response.
//   5. Reset mid-operation:
//      - Stimulus: assert rst_i while in RESP with rsp_ready_i=0.
//      - Response: outputs go to reset values immediately (async); the next grant
//        goes to requester 0.
//   6. Idle address hold:
//      - Stimulus: no requests for 5 cycles after a grant to address 0x1FFC.
//      - Response: mem_addr_o stays 0x1FFC; rsp_valid_o=0 once retired.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Optional feature macro used by the arbiter files: IMEM_ARB_FIXED_PRIO_EN.
package imem_arb_pkg;

   // IDLE: no response held. RESP: a registered response is held for the owner.
   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } arb_state_e;

   // Default requester count (core fetch + boot loader/debug reader).
   localparam int N_REQ_DEF = 2;

   // Widest one-hot vector the index helper understands.
   localparam int ONEHOT_MAX = 32;

   // Index of the set bit of a one-hot vector (lowest set bit if several).
   // Returns 0 for an all-zero vector.
   function automatic logic [4:0] onehot_to_idx(input logic [ONEHOT_MAX-1:0] onehot);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = ONEHOT_MAX - 1; i >= 0; i--) begin
         if (onehot[i]) begin
            idx = 5'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage : imem_arb_pkg

// File: rtl/imem_arbiter_rr.sv
// Request arbiter for imem_arbiter.
// Default: round-robin, the search starts at an internal pointer that moves to
// one past the winner whenever a grant is taken (advance_i).
// With IMEM_ARB_FIXED_PRIO_EN defined: plain priority encoder, lowest index
// wins and no pointer state exists.
module rr_arbiter
   import imem_arb_pkg::*;
#(
   parameter int N = N_REQ_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_i,
   input  logic                 advance_i,
   output logic [N-1:0]         gnt_onehot_o,
   output logic [$clog2(N)-1:0] gnt_idx_o
);

   localparam int IDX_W = $clog2(N);

   logic [N-1:0] gnt_onehot_s;
   logic         found_s;

`ifdef IMEM_ARB_FIXED_PRIO_EN

   // Clock, reset and advance have no use without pointer state.
   logic unused_s;
   assign unused_s = clk_i ^ rst_i ^ advance_i;

   // Fixed priority: first requester from index 0 upward wins.
   always_comb begin
      gnt_onehot_s = {N{1'b0}};
      found_s      = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found_s && req_i[k]) begin
            gnt_onehot_s[k] = 1'b1;
            found_s         = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

`else

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;

   // Round-robin search: first requesting index at or after the pointer, wrapping.
   always_comb begin
      int cand;
      cand         = 0;
      gnt_onehot_s = {N{1'b0}};
      found_s      = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr_q) + k) % N;
         if (!found_s && req_i[cand]) begin
            gnt_onehot_s[cand] = 1'b1;
            found_s            = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next pointer: one past the winner on a taken grant, otherwise unchanged.
   always_comb begin
      if (advance_i && found_s) begin
         if (gnt_idx_o == IDX_W'(N - 1)) begin
            ptr_d = {IDX_W{1'b0}};
         end else begin
            ptr_d = gnt_idx_o + IDX_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register; starts at requester 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= {IDX_W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

`endif

   assign gnt_onehot_o = gnt_onehot_s;
   assign gnt_idx_o    = IDX_W'(onehot_to_idx(ONEHOT_MAX'(gnt_onehot_s)));

endmodule : rr_arbiter

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one combinational-read memory port
// between N_REQ valid/ready requesters. One transaction in flight, registered
// response (1-cycle latency), 1 word/cycle when grants run back to back.
// Optional feature macro: IMEM_ARB_FIXED_PRIO_EN (fixed priority instead of
// round-robin, handled inside rr_arbiter).
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int IMEM_W = 13,
   parameter int N_REQ  = N_REQ_DEF
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   input  logic [N_REQ-1:0][IMEM_W-1:0]  req_addr_i,
   output logic [N_REQ-1:0]              req_ready_o,
   output logic [N_REQ-1:0]              rsp_valid_o,
   output logic [31:0]                   rsp_data_o,
   input  logic [N_REQ-1:0]              rsp_ready_i,
   output logic [IMEM_W-1:0]             mem_addr_o,
   input  logic [31:0]                   mem_rdata_i
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [31:0]       data_q, data_d;
   logic [IMEM_W-1:0] addr_q, addr_d;

   logic              can_accept_s;
   logic              grant_s;
   logic [N_REQ-1:0]  gnt_onehot_s;
   logic [IDX_W-1:0]  gnt_idx_s;

   // A new request fits when nothing is held, or the held response retires now.
   assign can_accept_s = (state_q == IDLE) ||
                         ((state_q == RESP) && rsp_ready_i[owner_q]);
   assign grant_s      = can_accept_s && (|req_valid_i);

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr_arbiter (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_i        (req_valid_i),
      .advance_i    (grant_s),
      .gnt_onehot_o (gnt_onehot_s),
      .gnt_idx_o    (gnt_idx_s)
   );

   // Next state: capture on grant (also while retiring), drop to IDLE on retire.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      data_d  = data_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (grant_s) begin
               state_d = RESP;
               owner_d = gnt_idx_s;
               data_d  = mem_rdata_i;
               addr_d  = req_addr_i[gnt_idx_s];
            end else begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (grant_s) begin
               // Back-to-back: retire and replace in the same cycle.
               state_d = RESP;
               owner_d = gnt_idx_s;
               data_d  = mem_rdata_i;
               addr_d  = req_addr_i[gnt_idx_s];
            end else if (rsp_ready_i[owner_q]) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, owner, response data and last granted address registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= {IDX_W{1'b0}};
         data_q  <= 32'h0000_0000;
         addr_q  <= {IMEM_W{1'b0}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
      end
   end

   // Channel outputs: live address on a grant, otherwise hold the last one so
   // the memory address does not toggle while idle.
   always_comb begin
      if (grant_s) begin
         req_ready_o = gnt_onehot_s;
         mem_addr_o  = req_addr_i[gnt_idx_s];
      end else begin
         req_ready_o = {N_REQ{1'b0}};
         mem_addr_o  = addr_q;
      end
      if (state_q == RESP) begin
         rsp_valid_o = N_REQ'(1) << owner_q;
      end else begin
         rsp_valid_o = {N_REQ{1'b0}};
      end
   end

   assign rsp_data_o = data_q;

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a transaction-level model predicts each
// grant and the response it must produce; a negedge monitor checks responses.
module tb_imem_arbiter;

   localparam int N = 2;
   localparam int W = 13;

   typedef struct {
      int          owner;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0][W-1:0]  req_addr;
   logic [N-1:0]         req_ready;
   logic [N-1:0]         rsp_valid;
   logic [31:0]          rsp_data;
   logic [N-1:0]         rsp_ready;
   logic [W-1:0]         mem_addr;
   logic [31:0]          mem_rdata;

   int   ncmp;
   int   nerr;
   int   cyc;
   exp_t q[$];

   // model: held response, its owner, search start, last address sent to memory
   bit          m_busy;
   int          m_owner;
   int          m_ptr;
   logic [W-1:0] m_last_addr;
   int          last_gnt;

   // requesters
   bit          pend[N];
   logic [W-1:0] areq[N];

   imem_arbiter #(.IMEM_W(W), .N_REQ(N)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_addr_i  (req_addr),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .rsp_ready_i (rsp_ready),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memf(input logic [W-1:0] a);
      if (a == 13'h010) return 32'hDEAD_BEEF;
      return 32'h5A00_0000 ^ ({19'd0, a} * 32'h9E37_79B1);
   endfunction

   // instruction memory: combinational read
   always_comb mem_rdata = memf(mem_addr);

   always_comb begin
      for (int i = 0; i < N; i++) req_addr[i] = areq[i];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // response monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (q.size() > 0 && q[0].cyc < cyc) begin
            check("rsp_valid", 32'(rsp_valid), 32'(1) << q[0].owner);
            check("rsp_data", rsp_data, q[0].data);
            if (rsp_ready[q[0].owner]) void'(q.pop_front());
         end else begin
            check("rsp_idle", 32'(rsp_valid), 32'd0);
         end
      end
   end

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_last_addr = '0; last_gnt = -1;
      for (int i = 0; i < N; i++) pend[i] = 0;
      q.delete();
   endtask

   // one cycle, entered at posedge+1, returns at next posedge+1
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr);
      bit   can;
      int   w;
      logic [N-1:0] exp_rdy;
      req_valid = v;
      rsp_ready = rr;
      #2;
      can = !m_busy || rr[m_owner];
      w = -1;
      if (can && v != 0) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
         for (int k = N - 1; k >= 0; k--) if (v[k]) w = k;
`else
         for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
      end
      exp_rdy = (w >= 0) ? N'(1) << w : '0;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (w >= 0) begin
         check("mem_addr_gnt", 32'(mem_addr), 32'(areq[w]));
         q.push_back('{owner: w, data: memf(areq[w]), cyc: cyc});
         m_busy = 1; m_owner = w; m_last_addr = areq[w]; m_ptr = (w + 1) % N;
      end else begin
         check("mem_addr_hold", 32'(mem_addr), 32'(m_last_addr));
         if (m_busy && rr[m_owner]) m_busy = 0;
      end
      last_gnt = w;
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
   endtask

   initial begin
      logic [N-1:0] v;
      ncmp = 0; nerr = 0; cyc = 0;
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      for (int i = 0; i < N; i++) areq[i] = '0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check_reset_outputs();
      rst = 1'b0;

      // single request
      areq[0] = 13'h010;
      step(2'b01, 2'b00);
      // backpressure three cycles (requester 1 also waiting), retire on fourth
      areq[1] = 13'h0A4;
      step(2'b10, 2'b00);
      step(2'b10, 2'b10);
      step(2'b10, 2'b00);
      step(2'b10, 2'b01);
      step(2'b00, 2'b11);

      // both requesters every cycle, all responses taken
      for (int i = 0; i < 8; i++) begin
         areq[0] = W'(13'h100 + 4 * i);
         areq[1] = W'(13'h800 + 4 * i + 1);
         step(2'b11, 2'b11);
      end
      step(2'b00, 2'b11);

      // back-to-back retire of 0 and accept of 1
      areq[0] = 13'h020; areq[1] = 13'h024;
      step(2'b01, 2'b00);
      step(2'b10, 2'b01);
      step(2'b00, 2'b10);

      // reset while a response is held and not accepted
      areq[0] = 13'h044;
      step(2'b01, 2'b00);
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      model_reset();
      #1;
      check_reset_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      areq[0] = 13'h0C0; areq[1] = 13'h0C4;
      step(2'b11, 2'b11);
      check("post_rst_gnt0", 32'(last_gnt), 32'd0);
      step(2'b00, 2'b11);

      // idle address hold at top of memory
      areq[1] = 13'h1FFC;
      step(2'b10, 2'b11);
      for (int i = 0; i < 5; i++) step(2'b00, 2'b11);

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
               pend[i] = 1;
               areq[i] = W'($urandom_range(0, 8191));
            end
         end
         for (int i = 0; i < N; i++) v[i] = pend[i];
         step(v, N'($urandom_range(0, 3)));
         if (last_gnt >= 0) pend[last_gnt] = 0;
      end

      // drain
      for (int i = 0; i < 4; i++) step(2'b00, 2'b11);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule : tb_imem_arbiter
